latch_comp: RTL and testbench



---
 rtl/latch_comp.sv | 62 ++++++
 tb/tb_latch_comp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_comp.sv
`default_nettype none
// ============================================================================
// Module   : latch_comp
// Brief    : Synchronous emulation of a transparent D latch with open/close
//            event pulses. The optional transparent-cycle counter is built only
//            when LATCH_COMP_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module latch_comp #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] q_held,
    output logic             open_evt,
    output logic             close_evt
`ifdef LATCH_COMP_STATS_EN
    ,
    output logic [15:0]      xparent_cnt
`endif
);

    logic [WIDTH-1:0] r_held;
    logic             r_en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= '0;
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (enable) begin
                r_held <= data;
            end
        end
    end

    // Transparent path stays live through reset; only the storage is cleared.
    assign q_out     = enable ? data : r_held;
    assign q_held    = r_held;
    assign open_evt  = ~rst &  enable & ~r_en_d;
    assign close_evt = ~rst & ~enable &  r_en_d;

`ifdef LATCH_COMP_STATS_EN
    logic [15:0] r_xparent_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xparent_cnt <= 16'h0000;
        end else if (enable && (r_xparent_cnt != 16'hFFFF)) begin
            r_xparent_cnt <= r_xparent_cnt + 16'h0001;
        end
    end

    assign xparent_cnt = r_xparent_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_latch_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_comp
// Brief    : Self-checking bench for latch_comp against a capture-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_latch_comp;

    localparam int C_WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [C_WIDTH-1:0] data;
    logic [C_WIDTH-1:0] q_out;
    logic [C_WIDTH-1:0] q_held;
    logic               open_evt;
    logic               close_evt;
`ifdef LATCH_COMP_STATS_EN
    logic [15:0]        xparent_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    // Reference model: the value captured at the most recent enabled edge,
    // whether the previous edge saw the latch open, and the transparent count.
    logic [C_WIDTH-1:0] m_capture;
    logic               m_was_open;
    int                 m_open_cycles;

    latch_comp #(.WIDTH(C_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data       (data),
        .q_out      (q_out),
        .q_held     (q_held),
        .open_evt   (open_evt),
        .close_evt  (close_evt)
`ifdef LATCH_COMP_STATS_EN
        ,
        .xparent_cnt(xparent_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic r, input logic e, input logic [C_WIDTH-1:0] d);
        rst    = r;
        enable = e;
        data   = d;
        #1;
    endtask

    // Advance one rising edge and apply the latch rules to the model.
    task automatic clk_edge();
        @(posedge clk);
        if (rst) begin
            m_capture     = '0;
            m_was_open    = 1'b0;
            m_open_cycles = 0;
        end else begin
            if (enable) begin
                m_capture = data;
                if (m_open_cycles < 65535) m_open_cycles++;
            end
            m_was_open = enable;
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 8'h00);
        clk_edge();
        set_in(1'b0, 1'b0, 8'h00);
        vectors++; if (q_out !== 8'h00) begin errors++; $display("FAIL reset_q_out got %h want 00", q_out); end
        vectors++; if (q_held !== 8'h00) begin errors++; $display("FAIL reset_q_held got %h want 00", q_held); end
        vectors++; if ({open_evt, close_evt} !== 2'b00) begin errors++; $display("FAIL reset_events got %b want 00", {open_evt, close_evt}); end
        set_in(1'b0, 1'b0, 8'h01);
        vectors++; if (q_out !== 8'h00) begin errors++; $display("FAIL closed_data_q_out got %h want 00", q_out); end
        clk_edge();
        vectors++; if (q_held !== 8'h00) begin errors++; $display("FAIL closed_data_q_held got %h want 00", q_held); end
    endtask

    task automatic test_open();
        set_in(1'b0, 1'b1, 8'h00);
        vectors++; if (q_out !== 8'h00) begin errors++; $display("FAIL open_q_out got %h want 00", q_out); end
        vectors++; if (open_evt !== 1'b1) begin errors++; $display("FAIL open_evt got %b want 1", open_evt); end
        clk_edge();
        vectors++; if (open_evt !== 1'b0) begin errors++; $display("FAIL open_evt_pulse got %b want 0", open_evt); end
        set_in(1'b0, 1'b1, 8'h01);
        vectors++; if (q_out !== 8'h01) begin errors++; $display("FAIL xparent_q_out got %h want 01", q_out); end
        vectors++; if (q_held !== 8'h00) begin errors++; $display("FAIL xparent_held_pre got %h want 00", q_held); end
        clk_edge();
        vectors++; if (q_held !== 8'h01) begin errors++; $display("FAIL xparent_held_post got %h want 01", q_held); end
    endtask

    task automatic test_close();
        set_in(1'b0, 1'b0, 8'h00);
        vectors++; if (q_out !== 8'h01) begin errors++; $display("FAIL close_q_out got %h want 01", q_out); end
        vectors++; if (close_evt !== 1'b1) begin errors++; $display("FAIL close_evt got %b want 1", close_evt); end
        clk_edge();
        vectors++; if (close_evt !== 1'b0) begin errors++; $display("FAIL close_evt_pulse got %b want 0", close_evt); end
        set_in(1'b0, 1'b0, 8'h01);
        clk_edge();
        set_in(1'b0, 1'b0, 8'h00);
        vectors++; if (q_out !== 8'h01) begin errors++; $display("FAIL hold_q_out got %h want 01", q_out); end
    endtask

    task automatic test_reopen();
        set_in(1'b0, 1'b1, 8'h00);
        vectors++; if (q_out !== 8'h00) begin errors++; $display("FAIL reopen_q_out got %h want 00", q_out); end
        vectors++; if (open_evt !== 1'b1) begin errors++; $display("FAIL reopen_evt got %b want 1", open_evt); end
        clk_edge();
        set_in(1'b0, 1'b0, 8'h00);
        vectors++; if (close_evt !== 1'b1) begin errors++; $display("FAIL reclose_evt got %b want 1", close_evt); end
        clk_edge();
        vectors++; if (q_out !== 8'h00) begin errors++; $display("FAIL reclose_q_out got %h want 00", q_out); end
        set_in(1'b0, 1'b1, 8'h01);
        vectors++; if (q_out !== 8'h01) begin errors++; $display("FAIL reopen2_q_out got %h want 01", q_out); end
    endtask

    task automatic test_reset_transparent();
        set_in(1'b1, 1'b1, 8'h01);
        vectors++; if (open_evt !== 1'b0) begin errors++; $display("FAIL rst_open_evt got %b want 0", open_evt); end
        vectors++; if (q_out !== 8'h01) begin errors++; $display("FAIL rst_xparent_q_out got %h want 01", q_out); end
        clk_edge();
        vectors++; if (q_out !== 8'h01) begin errors++; $display("FAIL rst_post_q_out got %h want 01", q_out); end
        vectors++; if (q_held !== 8'h00) begin errors++; $display("FAIL rst_post_q_held got %h want 00", q_held); end
        vectors++; if (open_evt !== 1'b0) begin errors++; $display("FAIL rst_post_open got %b want 0", open_evt); end
        set_in(1'b0, 1'b1, 8'h01);
        clk_edge();
        vectors++; if (q_held !== 8'h01) begin errors++; $display("FAIL rst_release_q_held got %h want 01", q_held); end
        // Simultaneous reset and falling enable: reset wins, no pulse.
        set_in(1'b1, 1'b0, 8'h5A);
        vectors++; if (close_evt !== 1'b0) begin errors++; $display("FAIL rst_close_evt got %b want 0", close_evt); end
        clk_edge();
        vectors++; if (q_out !== 8'h00) begin errors++; $display("FAIL rst_close_q_out got %h want 00", q_out); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [C_WIDTH-1:0] d;
            d = C_WIDTH'($urandom);
            set_in(1'b0, 1'b1, d);
            clk_edge();
            vectors++; if (q_held !== d) begin errors++; $display("FAIL b2b_track[%0d] got %h want %h", i, q_held, d); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic               r;
            logic               e;
            logic [C_WIDTH-1:0] d;
            logic [C_WIDTH-1:0] exp_q;
            r = ($urandom_range(0, 19) == 0);
            e = $urandom_range(0, 1) == 1;
            d = C_WIDTH'($urandom);
            set_in(r, e, d);
            exp_q = e ? d : m_capture;
            vectors++; if (q_out !== exp_q) begin errors++; $display("FAIL rand_q_out[%0d] got %h want %h", i, q_out, exp_q); end
            vectors++; if (q_held !== m_capture) begin errors++; $display("FAIL rand_q_held[%0d] got %h want %h", i, q_held, m_capture); end
            vectors++; if (open_evt !== (!r && e && !m_was_open)) begin errors++; $display("FAIL rand_open[%0d] got %b want %b", i, open_evt, (!r && e && !m_was_open)); end
            vectors++; if (close_evt !== (!r && !e && m_was_open)) begin errors++; $display("FAIL rand_close[%0d] got %b want %b", i, close_evt, (!r && !e && m_was_open)); end
`ifdef LATCH_COMP_STATS_EN
            vectors++; if (xparent_cnt !== 16'(m_open_cycles)) begin errors++; $display("FAIL rand_cnt[%0d] got %0d want %0d", i, xparent_cnt, m_open_cycles); end
`endif
            clk_edge();
        end
    endtask

`ifdef LATCH_COMP_STATS_EN
    task automatic test_stats();
        set_in(1'b1, 1'b0, 8'h00);
        clk_edge();
        vectors++; if (xparent_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset got %0d want 0", xparent_cnt); end
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, C_WIDTH'(i));
            clk_edge();
        end
        set_in(1'b0, 1'b0, 8'h00);
        clk_edge();
        vectors++; if (xparent_cnt !== 16'd5) begin errors++; $display("FAIL cnt_five got %0d want 5", xparent_cnt); end
        set_in(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 65535; i++) clk_edge();
        vectors++; if (xparent_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got %h want ffff", xparent_cnt); end
        clk_edge();
        vectors++; if (xparent_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold_sat got %h want ffff", xparent_cnt); end
        set_in(1'b1, 1'b1, 8'h00);
        clk_edge();
        vectors++; if (xparent_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", xparent_cnt); end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        data          = '0;
        m_capture     = '0;
        m_was_open    = 1'b0;
        m_open_cycles = 0;
        @(negedge clk);
        test_reset();
        test_open();
        test_close();
        test_reopen();
        test_reset_transparent();
        test_back_to_back();
        test_random();
`ifdef LATCH_COMP_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
